csa16_adder: RTL and testbench

- 16-bit unsigned binary adder with carry-in and carry-out, built as a carry-select adder of 4-bit blocks.
- The combinational sum path is captured in an output register, giving a single-clock, one-cycle-latency datapath element.
- Used wherever a registered 16-bit add is needed in the arithmetic datapath.

---
 rtl/csa_pkg.sv | 7 +
 rtl/csa_block.sv | 41 ++++
 rtl/csa16_adder.sv | 80 ++++++++
 tb/tb_csa16_adder.sv | 116 +++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared sizing constants for the carry-select adder datapath.
package csa_pkg;

   localparam int ADDER_WIDTH = 16;
   localparam int CSA_BLOCK   = 4;

endpackage

// File: rtl/csa_block.sv
// One carry-select stage: two ripple adders precompute both carry-in cases,
// and the incoming carry picks the finished result through 2:1 muxes.
module csa_block
   import csa_pkg::*;
#(
   parameter int BLOCK = CSA_BLOCK
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             sel,
   output logic [BLOCK-1:0] sum,
   output logic             cout
);

   logic [BLOCK-1:0] sum0;
   logic [BLOCK-1:0] sum1;
   logic             cout0;
   logic             cout1;

   // Both chains settle while the lower block's carry is still in flight.
   always_comb begin
      logic c0;
      logic c1;
      c0   = 1'b0;
      c1   = 1'b1;
      sum0 = '0;
      sum1 = '0;
      for (int i = 0; i < BLOCK; i++) begin
         sum0[i] = a[i] ^ b[i] ^ c0;
         c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
         sum1[i] = a[i] ^ b[i] ^ c1;
         c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
      end
      cout0 = c0;
      cout1 = c1;
   end

   assign sum  = sel ? sum1  : sum0;
   assign cout = sel ? cout1 : cout0;

endmodule

// File: rtl/csa16_adder.sv
// Registered unsigned adder {cout, s} = x + y + cin built from carry-select
// blocks; the result is captured one clock after the operands are sampled.
module csa16_adder
   import csa_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH,
   parameter int BLOCK = CSA_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int NUM_BLOCKS = WIDTH / BLOCK;

   logic [WIDTH-1:0] sum_c;
   logic             cout_c;
   logic [BLOCK-1:0] blk0_sum;
   logic             blk0_cout;

   // The lowest block sees cin directly, so a single ripple chain is enough.
   always_comb begin
      logic c;
      c        = cin;
      blk0_sum = '0;
      for (int i = 0; i < BLOCK; i++) begin
         blk0_sum[i] = x[i] ^ y[i] ^ c;
         c           = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      blk0_cout = c;
   end

   assign sum_c[BLOCK-1:0] = blk0_sum;

   for (genvar k = 1; k < NUM_BLOCKS; k++) begin : g_sel
      logic             sel_in;
      logic [BLOCK-1:0] blk_sum;
      logic             blk_cout;

      if (k == 1) begin : g_first
         assign sel_in = blk0_cout;
      end else begin : g_chain
         assign sel_in = g_sel[k-1].blk_cout;
      end

      csa_block #(
         .BLOCK (BLOCK)
      ) u_blk (
         .a    (x[k*BLOCK +: BLOCK]),
         .b    (y[k*BLOCK +: BLOCK]),
         .sel  (sel_in),
         .sum  (blk_sum),
         .cout (blk_cout)
      );

      assign sum_c[k*BLOCK +: BLOCK] = blk_sum;
   end

   if (NUM_BLOCKS > 1) begin : g_cout_sel
      assign cout_c = g_sel[NUM_BLOCKS-1].blk_cout;
   end else begin : g_cout_ripple
      assign cout_c = blk0_cout;
   end

   // Output register; reset wins over whatever is on the operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         s    <= '0;
         cout <= 1'b0;
      end else begin
         s    <= sum_c;
         cout <= cout_c;
      end
   end

endmodule

// File: tb/tb_csa16_adder.sv
// Scoreboard bench for csa16_adder: each driven vector pushes its expected
// 17-bit result, which is popped and checked one clock later.
module tb_csa16_adder;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         cin;
   logic [W-1:0] s;
   logic         cout;

   logic [W:0]   exp_q[$];
   int           tests_run;
   int           tests_failed;

   csa16_adder dut (
      .clk  (clk),
      .rst  (rst),
      .x    (x),
      .y    (y),
      .cin  (cin),
      .s    (s),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W:0] refSum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
      logic [W:0] r;
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      return r;
   endfunction

   // Drives one vector and records what the output register must hold after the next edge.
   task automatic applyStimulus(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c);
      rst = r;
      x   = a;
      y   = b;
      cin = c;
      if (r) exp_q.push_back('0);
      else   exp_q.push_back(refSum(a, b, c));
   endtask

   task automatic checkOutput(input string tag);
      logic [W:0] expv;
      @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $error("[TB] FAIL %s: scoreboard empty, got %h", tag, {cout, s});
      end else begin
         expv = exp_q.pop_front();
         assert ({cout, s} === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: got cout/s=%h expected %h", tag, {cout, s}, expv);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b1; x = '0; y = '0; cin = 1'b0;
      #2;

      applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b0); checkOutput("reset_cycle1");
      applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b0); checkOutput("reset_cycle2");
      applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0); checkOutput("first_after_reset");

      applyStimulus(1'b0, 16'hF800, 16'h07FF, 1'b0); checkOutput("no_carry_all_ones");
      applyStimulus(1'b0, 16'h0000, 16'hF800, 1'b1); checkOutput("cin_only");
      applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0); checkOutput("full_carry_wrap");
      applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 1'b1); checkOutput("max_plus_max_cin");
      applyStimulus(1'b0, 16'hFFFF, 16'h0000, 1'b1); checkOutput("max_plus_cin_wrap");
      applyStimulus(1'b0, 16'h000F, 16'h0001, 1'b0); checkOutput("block0_to_block1");
      applyStimulus(1'b0, 16'h0FFF, 16'h0000, 1'b1); checkOutput("block0_to_block3");
      applyStimulus(1'b0, 16'h00F0, 16'h0010, 1'b0); checkOutput("block1_to_block2");
      applyStimulus(1'b0, 16'h8000, 16'h8000, 1'b0); checkOutput("top_block_cout");

      for (int i = 0; i < 10000; i++) begin
         applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
         checkOutput("random_stream");
      end

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
         checkOutput("pre_reset_stream");
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom));
         checkOutput("mid_stream_reset");
      end
      applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b1); checkOutput("resume_after_reset");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
         checkOutput("post_reset_stream");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
